d_latch_bank: RTL and testbench
===============================

Name: d_latch_bank

Overview:
- Parametrised successor to the single-bit resettable D-latch: CHANNELS independent WIDTH-bit storage channels, fully clocked, double-buffered.
- Per-channel load enables write a staging register; a request/acknowledge commit transfers all pending channels to the outputs atomically in one cycle.
- Used wherever several control fields must update together, e.g. mode/config words driven across a block boundary.

Parameters:
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of channels
- RESET_VAL, 0, value of every stage and q channel after reset or clear (WIDTH bits)
- CNT_W, 8, width of the saturating commit counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  CHANNELS  per-channel stage load enable
- d  input  CHANNELS*WIDTH  stage data; channel i = d[i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of stage, q, pending and counter
- commit_req  input  1  commit request, level, 4-phase
- commit_ack  output  1  one-cycle commit acknowledge
- q  output  CHANNELS*WIDTH  committed output data
- pending  output  CHANNELS  channel staged but not yet committed
- commit_cnt  output  CNT_W  number of effective commits, saturating

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): stage=q=RESET_VAL, pending=0, commit_ack=0, commit_cnt=0, FSM=IDLE. Deassertion is sampled at clk; no partial update on the release edge.
- Priority per edge: clr > commit > ena.
- clr=1: stage, q = RESET_VAL; pending=0; commit_cnt=0; FSM=IDLE; commit_ack=0. ena and commit_req are ignored that cycle.
- Stage load: ena[i]=1 -> stage[i] <= d slice i, pending[i] <= 1. Repeated loads before a commit overwrite; the last value wins.
- FSM states are IDLE, ACK and WAIT.
  - IDLE, commit_req=1: on this edge, q[i] <= stage[i] for every i with pending[i]=1, and those pending bits clear. Go to ACK.
  - ACK: commit_ack=1 for exactly this one cycle. Next state is WAIT if commit_req=1, otherwise IDLE.
  - WAIT: stay until commit_req=0, then go to IDLE.
  - commit_ack is registered: it is high the cycle after the commit edge, and q is already updated in that cycle.
- ena[i] on the same edge as a commit: stage[i] takes the new d, the commit uses the old stage[i] only if pending[i] was already 1, and pending[i] ends at 1. The new value waits for the next commit.
- commit_req held high: exactly one commit per request. A new commit needs a low phase first.
- A commit with pending=0 still acknowledges. q and commit_cnt are unchanged.
- commit_cnt increments by 1 per commit with at least one pending bit set. It saturates at 2^CNT_W-1 and does not wrap.
- Channels without a pending bit keep q unchanged across a commit.
- ena and d are ignored while rst_n=0.

Optional Feature:
- Macro: D_LATCH_BANK_PARITY_EN.
- Defined: extra output q_par [CHANNELS], registered; q_par[i] = even parity (XOR reduction) of q[i], updated on the same edge as q. The reset/clr value is the parity of RESET_VAL.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package d_latch_bank_pkg:
  - FSM state typedef: IDLE, ACK, WAIT.
  - Default WIDTH/CHANNELS/CNT_W constants.
  - Helper function for channel slice offset.
- One sub-module, d_latch_bank_chan:
  - Holds one channel's stage, q and pending bit.
  - Inputs: ena, d, commit pulse, clr.
  - Instantiated CHANNELS times in a generate loop.
- The FSM and counter stay in the top module.

Test Plan:
- Reset and clear: rst_n=0 mid-run with WIDTH=8, RESET_VAL=8'h00 -> q=0 and pending=0 immediately, without waiting for a clock edge. After release, ena=4'b0001, d ch0=8'hA5 -> pending=4'b0001 and q unchanged.
- Atomic commit: stage ch0=8'h11, ch2=8'h33, then a 1-cycle commit_req -> both q slices update on the same edge. commit_ack is high one cycle later, pending=0, commit_cnt=1, and ch1/ch3 are unchanged.
- Collision: pending[1]=1 with stage=8'h22, then ena[1] with d=8'h44 on the commit edge -> q ch1=8'h22, pending[1]=1. The next commit gives q ch1=8'h44.
- Held request: commit_req high for 6 cycles -> exactly one commit_ack pulse. A second commit happens only after commit_req goes low then high again.
- Empty commit and saturation: a commit with pending=0 -> ack, commit_cnt unchanged. With CNT_W=2, 5 effective commits -> commit_cnt=3.
- clr priority: clr, commit_req and ena all high together -> q=RESET_VAL, pending=0, no ack, commit_cnt=0.

Source files
------------

// File: rtl/d_latch_bank_pkg.sv
// Shared types and constants for the d_latch_bank double-buffered register bank.
package d_latch_bank_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefChannels = 4;
  localparam int unsigned DefCntW     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StWait
  } state_e;

  // Bit offset of channel idx inside a packed CHANNELS*WIDTH bus.
  function automatic int unsigned chan_off(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/d_latch_bank_chan.sv
// One channel of d_latch_bank: stage register, committed output and pending flag.
// Optional registered parity output under D_LATCH_BANK_PARITY_EN.
module d_latch_bank_chan #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             commit_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o,
`ifdef D_LATCH_BANK_PARITY_EN
  output logic             q_par_o,
`endif
  output logic             pending_o
);

  logic [WIDTH-1:0] stage_d, stage_q;
  logic [WIDTH-1:0] q_d, q_q;
  logic             pending_d, pending_q;

  always_comb begin
    stage_d   = stage_q;
    q_d       = q_q;
    pending_d = pending_q;
    if (clr_i) begin
      stage_d   = RESET_VAL;
      q_d       = RESET_VAL;
      pending_d = 1'b0;
    end else begin
      // Commit consumes the old stage; a same-edge load re-arms pending.
      if (commit_i && pending_q) begin
        q_d       = stage_q;
        pending_d = 1'b0;
      end
      if (ena_i) begin
        stage_d   = d_i;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= RESET_VAL;
      q_q       <= RESET_VAL;
      pending_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      q_q       <= q_d;
      pending_q <= pending_d;
    end
  end

  assign q_o       = q_q;
  assign pending_o = pending_q;

`ifdef D_LATCH_BANK_PARITY_EN
  logic par_d, par_q;

  assign par_d = ^q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= ^RESET_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  assign q_par_o = par_q;
`endif

endmodule

// File: rtl/d_latch_bank.sv
// CHANNELS x WIDTH double-buffered register bank with atomic 4-phase commit.
// Define D_LATCH_BANK_PARITY_EN to add the registered per-channel q_par output.
module d_latch_bank
  import d_latch_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefWidth,
  parameter int unsigned      CHANNELS  = DefChannels,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = DefCntW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       ena,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      clr,
  input  logic                      commit_req,
  output logic                      commit_ack,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       pending,
`ifdef D_LATCH_BANK_PARITY_EN
  output logic [CHANNELS-1:0]       q_par,
`endif
  output logic [CNT_W-1:0]          commit_cnt
);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              commit_go;

  // Only an IDLE-state request commits, so a held request commits once.
  assign commit_go = (state_q == StIdle) && commit_req && !clr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    d_latch_bank_chan #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena_i    (ena[i]),
      .d_i      (d[chan_off(i, WIDTH) +: WIDTH]),
      .commit_i (commit_go),
      .clr_i    (clr),
      .q_o      (q[chan_off(i, WIDTH) +: WIDTH]),
`ifdef D_LATCH_BANK_PARITY_EN
      .q_par_o  (q_par[i]),
`endif
      .pending_o(pending[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (commit_req) state_d = StAck;
        StAck:   state_d = commit_req ? StWait : StIdle;
        StWait:  if (!commit_req) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (commit_go && (|pending) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign commit_ack = (state_q == StAck);
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_d_latch_bank.sv
// Scoreboard bench for d_latch_bank (WIDTH=8, CHANNELS=4, RESET_VAL=0, CNT_W=2).
module tb_d_latch_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 2;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     ena;
  logic [CH*W-1:0]   d;
  logic              clr;
  logic              commit_req;
  logic              commit_ack;
  logic [CH*W-1:0]   q;
  logic [CH-1:0]     pending;
  logic [CW-1:0]     commit_cnt;
`ifdef D_LATCH_BANK_PARITY_EN
  logic [CH-1:0]     q_par;
`endif

  d_latch_bank #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .RESET_VAL(8'h00),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .d         (d),
    .clr       (clr),
    .commit_req(commit_req),
    .commit_ack(commit_ack),
    .q         (q),
    .pending   (pending),
`ifdef D_LATCH_BANK_PARITY_EN
    .q_par     (q_par),
`endif
    .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*W-1:0] q;
    logic [CH-1:0]   pend;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every acknowledge must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && commit_ack === 1'b1) begin
      exp_t e;
      ack_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack with empty queue, expected none");
      end else begin
        e = exp_q.pop_front();
        check("ack_q", q, e.q);
        check("ack_pending", {28'd0, pending}, {28'd0, e.pend});
        check("ack_cnt", {30'd0, commit_cnt}, {30'd0, e.cnt});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [CH-1:0] en, input logic [CH*W-1:0] data);
    ena = en;
    d   = data;
    cycle();
    ena = '0;
    d   = '0;
  endtask

  // One-cycle request; en/data are loaded on the commit edge itself.
  task automatic commit_pulse(input logic [CH*W-1:0] eq, input logic [CH-1:0] ep,
                              input logic [CW-1:0] ec, input logic [CH-1:0] en,
                              input logic [CH*W-1:0] data);
    exp_q.push_back('{q: eq, pend: ep, cnt: ec});
    commit_req = 1'b1;
    ena        = en;
    d          = data;
    cycle();
    commit_req = 1'b0;
    ena        = '0;
    d          = '0;
    cycle();
    cycle();
  endtask

  int acks_before;

  initial begin
    rst_n      = 1'b0;
    ena        = '0;
    d          = '0;
    clr        = 1'b0;
    commit_req = 1'b0;
    cycle();
    cycle();
    check("reset_q", q, 32'h0);
    check("reset_pending", {28'd0, pending}, 32'h0);
    check("reset_cnt", {30'd0, commit_cnt}, 32'h0);
    check("reset_ack", {31'd0, commit_ack}, 32'h0);
    rst_n = 1'b1;
    cycle();

    load(4'b0001, 32'h0000_00A5);
    check("load_pending", {28'd0, pending}, 32'h1);
    check("load_q_unchanged", q, 32'h0);

    // Asynchronous reset mid-cycle, with loads attempted while in reset.
    #2;
    rst_n = 1'b0;
    ena   = 4'b1111;
    d     = 32'hFFFF_FFFF;
    #1;
    check("async_rst_pending", {28'd0, pending}, 32'h0);
    check("async_rst_q", q, 32'h0);
    @(negedge clk);
    cycle();
    check("rst_ignores_ena", {28'd0, pending}, 32'h0);
    ena   = '0;
    d     = '0;
    rst_n = 1'b1;
    cycle();

    // Atomic commit of ch0 and ch2.
    load(4'b0101, 32'h0033_0011);
    check("stage_pending", {28'd0, pending}, 32'h5);
    commit_pulse(32'h0033_0011, 4'b0000, 2'd1, 4'b0000, 32'h0);

    // Empty commit: acknowledged, counter holds.
    commit_pulse(32'h0033_0011, 4'b0000, 2'd1, 4'b0000, 32'h0);

    // Collision: old stage commits, new data stays pending.
    load(4'b0010, 32'h0000_2200);
    commit_pulse(32'h0033_2211, 4'b0010, 2'd2, 4'b0010, 32'h0000_4400);
    commit_pulse(32'h0033_4411, 4'b0000, 2'd3, 4'b0000, 32'h0);

    // Held request: one ack only; a later load must not be committed.
    load(4'b1000, 32'h7700_0000);
    acks_before = ack_cnt;
    exp_q.push_back('{q: 32'h7733_4411, pend: 4'b0000, cnt: 2'd3});
    commit_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ena = (i == 2) ? 4'b0001 : 4'b0000;
      d   = (i == 2) ? 32'h0000_0055 : 32'h0;
      cycle();
    end
    ena = '0;
    d   = '0;
    check("held_one_ack", ack_cnt - acks_before, 32'd1);
    check("held_pending", {28'd0, pending}, 32'h1);
    check("held_q", q, 32'h7733_4411);
    commit_req = 1'b0;
    cycle();
    commit_pulse(32'h7733_4455, 4'b0000, 2'd3, 4'b0000, 32'h0);
    check("saturated_cnt", {30'd0, commit_cnt}, 32'd3);

    // clr beats commit and ena.
    load(4'b0100, 32'h0099_0000);
    clr        = 1'b1;
    commit_req = 1'b1;
    ena        = 4'b1111;
    d          = 32'hFFFF_FFFF;
    cycle();
    clr        = 1'b0;
    commit_req = 1'b0;
    ena        = '0;
    d          = '0;
    check("clr_q", q, 32'h0);
    check("clr_pending", {28'd0, pending}, 32'h0);
    check("clr_cnt", {30'd0, commit_cnt}, 32'h0);
    check("clr_no_ack", {31'd0, commit_ack}, 32'h0);
    cycle();
    check("clr_no_late_ack", {31'd0, commit_ack}, 32'h0);

    load(4'b0010, 32'h0000_AB00);
    commit_pulse(32'h0000_AB00, 4'b0000, 2'd1, 4'b0000, 32'h0);

    cycle();
    check("queue_drained", exp_q.size(), 32'd0);
    check("total_acks", ack_cnt, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
